// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the fixed datapath width.
// Imported by alu and alu_addsub.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu_addsub.sv
// Purpose: 33-bit adder/subtractor, SUB done as a + ~b + 1 on one carry chain.
// Latency: purely combinational, no state.
// Backpressure: none; output follows inputs continuously.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             sub,
    output logic [ALU_W-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [ALU_W-1:0] b_eff;
    logic [ALU_W:0]   total;

    assign b_eff = sub ? ~b : b;
    assign total = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};

    assign sum   = total[ALU_W-1:0];
    assign carry = total[ALU_W];

    // Signed overflow: operands agree in sign but the sum does not.
    assign overflow = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);

endmodule

// File: rtl/alu.sv
// Purpose: 32-bit ADD/SUB/AND/OR with registered result; ALU_FLAGS_EN adds zero/negative/carry/overflow registers.
// Latency: 1 cycle, register loads every edge; synchronous active-high reset has priority.
// Backpressure: none; no handshake or enable, a new operation is accepted every cycle.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       control,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    output logic [ALU_W-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
`endif
);

    alu_op_t          op;
    logic [ALU_W-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic [ALU_W-1:0] next_result;
    logic             is_arith;

    assign op       = alu_op_t'(control);
    assign is_arith = (op == ALU_ADD) || (op == ALU_SUB);

    alu_addsub u_addsub (
        .a        (A),
        .b        (B),
        .sub      (op == ALU_SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    always_comb begin
        next_result = '0;
        case (op)
            ALU_ADD: next_result = as_sum;
            ALU_SUB: next_result = as_sum;
            ALU_AND: next_result = A & B;
            ALU_OR:  next_result = A | B;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else begin
            result <= next_result;
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            zero     <= 1'b1;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            zero     <= (next_result == '0);
            negative <= next_result[ALU_W-1];
            carry    <= is_arith & as_carry;
            overflow <= is_arith & as_ovf;
        end
    end
`else
    // Adder status is only consumed by the flag registers.
    logic unused_status;
    assign unused_status = as_carry ^ as_ovf ^ is_arith;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues the hand-computed response for each edge,
// a monitor pops and compares one entry after every rising edge.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  control = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] result;
`ifdef ALU_FLAGS_EN
    logic        zero, negative, carry, overflow;
`endif

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;   // {zero, negative, carry, overflow}
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk      (clk),
        .reset    (reset),
        .control  (control),
        .A        (A),
        .B        (B),
        .result   (result)
`ifdef ALU_FLAGS_EN
        ,
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow)
`endif
    );

    task automatic apply(input string nm, input logic r, input logic [1:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        reset   = r;
        control = c;
        A       = a;
        B       = b;
        e.res   = er;
        e.flg   = ef;
        e.name  = nm;
        q.push_back(e);
    endtask

    // Monitor: each entry describes what the registers hold after the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                if (result !== e.res) begin
                    n_bad++;
                    $display("FAIL %s result: got %h expected %h", e.name, result, e.res);
                end
`ifdef ALU_FLAGS_EN
                if ({zero, negative, carry, overflow} !== e.flg) begin
                    n_bad++;
                    $display("FAIL %s flags(z,n,c,v): got %b expected %b",
                             e.name, {zero, negative, carry, overflow}, e.flg);
                end
`endif
            end
        end
    end

    initial begin
        int wait_cyc;
        // Reset state.
        apply("reset",      1'b1, 2'b00, 32'h75,       32'h6B, 32'h0,        4'b1000);
        apply("sub71_69",   1'b0, 2'b01, 32'h71,       32'h69, 32'h08,       4'b0010);
        apply("or71_69",    1'b0, 2'b11, 32'h71,       32'h69, 32'h79,       4'b0000);
        apply("and71_69",   1'b0, 2'b10, 32'h71,       32'h69, 32'h61,       4'b0000);
        apply("add75_6b",   1'b0, 2'b00, 32'h75,       32'h6B, 32'hE0,       4'b0000);
        apply("and75_6b",   1'b0, 2'b10, 32'h75,       32'h6B, 32'h61,       4'b0000);
        apply("and_hold1",  1'b0, 2'b10, 32'h75,       32'h6B, 32'h61,       4'b0000);
        apply("and_hold2",  1'b0, 2'b10, 32'h75,       32'h6B, 32'h61,       4'b0000);
        apply("add_ovf",    1'b0, 2'b00, 32'h7FFFFFFF, 32'h1,  32'h80000000, 4'b0101);
        apply("sub_borrow", 1'b0, 2'b01, 32'h0,        32'h1,  32'hFFFFFFFF, 4'b0100);
        apply("sub_equal",  1'b0, 2'b01, 32'h5,        32'h5,  32'h0,        4'b1010);
        apply("add_wrap",   1'b0, 2'b00, 32'hFFFFFFFF, 32'h1,  32'h0,        4'b1010);
        apply("sub_ovf",    1'b0, 2'b01, 32'h80000000, 32'h1,  32'h7FFFFFFF, 4'b0011);
        apply("or_neg",     1'b0, 2'b11, 32'h80000000, 32'h1,  32'h80000001, 4'b0100);
        // Reset in the middle of a live ADD stream, then recovery.
        apply("pre_reset",  1'b0, 2'b00, 32'h75,       32'h6B, 32'hE0,       4'b0000);
        apply("mid_reset",  1'b1, 2'b00, 32'h75,       32'h6B, 32'h0,        4'b1000);
        apply("post_reset", 1'b0, 2'b00, 32'h75,       32'h6B, 32'hE0,       4'b0000);
        apply("and_zero",   1'b0, 2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,  4'b1000);

        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
